// File: rtl/tiny_dnn_pkg.sv
// Shared definitions for the tiny_dnn parameter-load path.
// Lane count default, idle group select and the load FSM states.
package tiny_dnn_pkg;

  localparam int F_NUM_DEF = 16;

  localparam logic [3:0] PRM_IDLE_SEL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } prm_state_e;

endpackage

// File: rtl/prm_load_ctrl.sv
// Parameter load controller: steers a 4-lane beat stream into
// tiny_dnn_core weight/bias slots, one write group at a time.
module prm_load_ctrl
  import tiny_dnn_pkg::*;
#(
  parameter int F_NUM = F_NUM_DEF,
  parameter int GRP   = F_NUM / 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       bwrite,
  input  logic [9:0] fs,
  input  logic       hold,
  input  logic       src_valid,
  input  logic       src_last,
  output logic       src_ready,
  output logic       wr_en,
  output logic [3:0] prm_v,
  output logic [9:0] prm_a,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [3:0] GRP_LAST = 4'(GRP - 1);

  prm_state_e state_q;
  logic [3:0] prm_v_q;
  logic [9:0] prm_a_q;
  logic [9:0] lim_m1_q;
  logic       err_q;

  logic       a_wrap;
  logic       final_beat;

  assign src_ready  = (state_q == ST_LOAD) & ~hold;
  assign wr_en      = src_valid & src_ready;
  assign a_wrap     = (prm_a_q == lim_m1_q);
  assign final_beat = a_wrap & (prm_v_q == GRP_LAST);

  assign prm_v = prm_v_q;
  assign prm_a = prm_a_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      prm_v_q  <= PRM_IDLE_SEL;
      prm_a_q  <= '0;
      lim_m1_q <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            err_q    <= 1'b0;
            prm_v_q  <= '0;
            prm_a_q  <= '0;
            // store lim-1 so the wrap compare needs no subtractor
            lim_m1_q <= bwrite ? 10'd0 : fs - 10'd1;
            if (!bwrite && fs == 10'd0) begin
              state_q <= ST_DONE;
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (wr_en) begin
            if (final_beat) begin
              state_q <= ST_DONE;
              err_q   <= err_q | ~src_last;
              prm_a_q <= '0;
              prm_v_q <= prm_v_q + 4'd1;
            end else if (src_last) begin
              state_q <= ST_DONE;
              err_q   <= 1'b1;
            end else if (a_wrap) begin
              prm_a_q <= '0;
              prm_v_q <= prm_v_q + 4'd1;
            end else begin
              prm_a_q <= prm_a_q + 10'd1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          prm_v_q <= PRM_IDLE_SEL;
          prm_a_q <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prm_load_ctrl.sv
// Directed bench for prm_load_ctrl with an address scoreboard.
module tb_prm_load_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       bwrite;
  logic [9:0] fs;
  logic       hold;
  logic       src_valid;
  logic       src_last;
  logic       src_ready;
  logic       wr_en;
  logic [3:0] prm_v;
  logic [9:0] prm_a;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  logic [13:0] exp_q[$];

  always #5 clk = ~clk;

  prm_load_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bwrite    (bwrite),
    .fs        (fs),
    .hold      (hold),
    .src_valid (src_valid),
    .src_last  (src_last),
    .src_ready (src_ready),
    .wr_en     (wr_en),
    .prm_v     (prm_v),
    .prm_a     (prm_a),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_err);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".v"}, 32'(prm_v), 32'hF);
    chk({tag, ".a"}, 32'(prm_a), 0);
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    chk({tag, ".rdy"}, 32'(src_ready), 0);
  endtask

  // Start a load and stream beats. hold_at: accepted-beat count at
  // which hold is raised for hold_len cycles. last_idx: 1-based beat
  // carrying src_last (0 = none). rst_at: 1-based beat during which
  // rst_n is pulled low (0 = never).
  task automatic run_load(input string tag, input logic bw,
                          input int f, input int nbeats,
                          input int last_idx, input int hold_at,
                          input int hold_len, input logic exp_err,
                          input int rst_at);
    int lim;
    int beats;
    int hcnt;
    int cyc;
    logic [13:0] e;
    lim = bw ? 1 : f;
    exp_q.delete();
    @(negedge clk);
    start  = 1'b1;
    bwrite = bw;
    fs     = 10'(f);
    #1;
    chk({tag, ".idle_rdy"}, 32'(src_ready), 0);
    for (int i = 0; i < nbeats; i++)
      exp_q.push_back({4'(i / lim), 10'(i % lim)});
    @(negedge clk);
    start = 1'b0;
    bwrite = 1'b0;
    fs = 10'd7;
    chk({tag, ".start_err"}, 32'(err), 0);
    chk({tag, ".busy"}, 32'(busy), 1);
    beats = 0;
    hcnt  = 0;
    cyc   = 0;
    while (beats < nbeats && cyc < 200) begin
      cyc++;
      src_valid = 1'b1;
      src_last  = (beats + 1 == last_idx);
      hold      = (beats == hold_at && hcnt < hold_len);
      start     = hold && hcnt == 0;
      bwrite    = 1'b1;
      #1;
      e = exp_q[0];
      if (hold) begin
        hcnt++;
        chk({tag, ".hold_rdy"}, 32'(src_ready), 0);
        chk({tag, ".hold_wr"}, 32'(wr_en), 0);
        chk({tag, ".hold_v"}, 32'(prm_v), 32'(e[13:10]));
        chk({tag, ".hold_a"}, 32'(prm_a), 32'(e[9:0]));
      end else begin
        chk({tag, ".wr"}, 32'(wr_en), 1);
        e = exp_q.pop_front();
        chk({tag, ".v"}, 32'(prm_v), 32'(e[13:10]));
        chk({tag, ".a"}, 32'(prm_a), 32'(e[9:0]));
        beats++;
        if (beats == rst_at) begin
          rst_n = 1'b0;
          #1;
          chk_idle({tag, ".rst"}, 1'b0);
          chk({tag, ".rst_wr"}, 32'(wr_en), 0);
          break;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    hold = 1'b0;
    src_valid = 1'b0;
    src_last = 1'b0;
    if (rst_at != 0) begin
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk({tag, ".no_done"}, 32'(done), 0);
        chk({tag, ".no_busy"}, 32'(busy), 0);
      end
      return;
    end
    if (cyc >= 200) chk({tag, ".timeout"}, 0, 1);
    #1;
    chk({tag, ".done"}, 32'(done), 1);
    chk({tag, ".busy_d"}, 32'(busy), 1);
    chk({tag, ".err_d"}, 32'(err), 32'(exp_err));
    chk({tag, ".rdy_d"}, 32'(src_ready), 0);
    @(negedge clk);
    chk_idle({tag, ".end"}, exp_err);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bwrite = 1'b0;
    fs = 10'd0;
    hold = 1'b0;
    src_valid = 1'b0;
    src_last = 1'b0;
    #12;
    chk_idle("reset", 1'b0);
    src_valid = 1'b1;
    src_last = 1'b1;
    #1;
    chk("reset_wr", 32'(wr_en), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("idle_stray_last", 1'b0);
    src_valid = 1'b0;
    src_last = 1'b0;

    run_load("w3", 1'b0, 3, 12, 12, -1, 0, 1'b0, 0);
    run_load("b25", 1'b1, 25, 4, 4, -1, 0, 1'b0, 0);
    run_load("w2h", 1'b0, 2, 8, 8, 2, 3, 1'b0, 0);
    run_load("w4ab", 1'b0, 4, 5, 5, -1, 0, 1'b1, 0);
    run_load("w1nl", 1'b0, 1, 4, 0, -1, 0, 1'b1, 0);
    run_load("w1ok", 1'b0, 1, 4, 4, -1, 0, 1'b0, 0);

    @(negedge clk);
    start = 1'b1;
    bwrite = 1'b0;
    fs = 10'd0;
    @(negedge clk);
    start = 1'b0;
    src_valid = 1'b1;
    #1;
    chk("fs0.rdy", 32'(src_ready), 0);
    chk("fs0.wr", 32'(wr_en), 0);
    chk("fs0.done", 32'(done), 1);
    chk("fs0.err", 32'(err), 1);
    @(negedge clk);
    src_valid = 1'b0;
    chk_idle("fs0.end", 1'b1);

    run_load("w4rst", 1'b0, 4, 6, 0, -1, 0, 1'b0, 6);
    run_load("w2post", 1'b0, 2, 8, 8, -1, 0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
